// File: rtl/vector_scalar_alu.sv
// rtl/vector_scalar_alu.sv - element-wise signed saturating vector-scalar ALU, 2-stage pipeline
module vector_scalar_alu #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int VECTOR_SIZE = 6272
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] scalar,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);
    localparam int W     = DATA_WIDTH;
    localparam int WIDE  = 2 * W + 1;
    localparam int IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;

    localparam logic signed [WIDE-1:0] SAT_MAX = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [WIDE-1:0] SAT_MIN = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};
    localparam logic signed [WIDE-1:0] MUL_RND = WIDE'(1) <<< (FRAC_BITS - 1);

    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_RELU = 3'd4,
        OP_MAX  = 3'd5,
        OP_MIN  = 3'd6,
        OP_ABS  = 3'd7
    } op_e;

    logic [IDX_W-1:0]       elem_idx;
    op_e                    op_q;
    logic [W-1:0]           scalar_q;
    logic                   adv, accept, first_elem, last_elem;
    op_e                    cur_op;
    logic [W-1:0]           cur_scalar;
    logic signed [WIDE-1:0] a_w, s_w, prod, raw_d;
    logic                   s1_valid, s1_last;
    logic signed [WIDE-1:0] s1_raw;
    logic [W-1:0]           sat_d;

    assign adv        = !out_valid || out_ready;
    assign in_ready   = adv;
    assign accept     = in_valid && adv;
    assign first_elem = (elem_idx == '0);
    assign last_elem  = (elem_idx == IDX_W'(VECTOR_SIZE - 1));
    assign busy       = s1_valid || out_valid;

    // Element 0 must already see the op/scalar presented alongside it.
    assign cur_op     = first_elem ? op_e'(op) : op_q;
    assign cur_scalar = first_elem ? scalar : scalar_q;

    assign a_w  = WIDE'($signed(in_data));
    assign s_w  = WIDE'($signed(cur_scalar));
    assign prod = a_w * s_w;

    always_comb begin
        raw_d = a_w;
        case (cur_op)
            OP_PASS: raw_d = a_w;
            OP_ADD:  raw_d = a_w + s_w;
            OP_SUB:  raw_d = a_w - s_w;
            OP_MUL:  raw_d = (prod + MUL_RND) >>> FRAC_BITS;
            OP_RELU: raw_d = (a_w < 0) ? '0 : a_w;
            OP_MAX:  raw_d = (a_w > s_w) ? a_w : s_w;
            OP_MIN:  raw_d = (a_w < s_w) ? a_w : s_w;
            OP_ABS:  raw_d = (a_w < 0) ? -a_w : a_w;
            default: raw_d = a_w;
        endcase
    end

    always_comb begin
        sat_d = s1_raw[W-1:0];
        if (s1_raw > SAT_MAX)
            sat_d = SAT_MAX[W-1:0];
        else if (s1_raw < SAT_MIN)
            sat_d = SAT_MIN[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_idx <= '0;
            op_q     <= OP_PASS;
            scalar_q <= '0;
        end else if (accept) begin
            elem_idx <= last_elem ? '0 : elem_idx + IDX_W'(1);
            if (first_elem) begin
                op_q     <= op_e'(op);
                scalar_q <= scalar;
            end
        end
    end

    // Both stages shift together whenever the output slot is free or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_raw    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            s1_valid  <= accept;
            if (accept) begin
                s1_raw  <= raw_d;
                s1_last <= last_elem;
            end
            out_valid <= s1_valid;
            out_last  <= s1_valid && s1_last;
            if (s1_valid)
                out_data <= sat_d;
        end
    end
endmodule

// File: tb/tb_vector_scalar_alu.sv
// tb/tb_vector_scalar_alu.sv - directed self-checking bench for vector_scalar_alu (VECTOR_SIZE=4 build)
module tb_vector_scalar_alu;
    localparam int VS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] scalar;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int passed = 0;

    vector_scalar_alu #(.DATA_WIDTH(16), .FRAC_BITS(8), .VECTOR_SIZE(VS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .scalar(scalar),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Feeds one full vector back-to-back; op/scalar are scrambled after element 0.
    task automatic run_vec(input string tag, input logic [2:0] vop, input logic [15:0] vs,
                           input logic [0:3][15:0] a, input logic [0:3][15:0] e);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                in_valid = 1'b1;
                in_data  = a[i];
                op       = (i == 0) ? vop : 3'd0;
                scalar   = (i == 0) ? vs : 16'h7777;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i == 0) begin
                check({tag, "_lat_valid"}, out_valid, 1'b0);
            end else begin
                check($sformatf("%s_v%0d", tag, i - 1), out_valid, 1'b1);
                check($sformatf("%s_d%0d", tag, i - 1), out_data, e[i-1]);
                check($sformatf("%s_l%0d", tag, i - 1), out_last, (i == 4));
            end
        end
        tick();
        check({tag, "_drain_valid"}, out_valid, 1'b0);
        check({tag, "_drain_busy"}, busy, 1'b0);
    endtask

    logic [15:0] bp_exp [8];
    logic [15:0] held;
    logic        stalled;
    int          sent, recv;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; op = '0; scalar = '0; out_ready = 1'b1;
        #12;
        check("rst_out_data", out_data, 16'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        run_vec("pass", 3'd0, 16'h0, '{16'h0001, 16'h0002, 16'h0003, 16'h0004},
                                     '{16'h0001, 16'h0002, 16'h0003, 16'h0004});
        run_vec("add", 3'd1, 16'h0200, '{16'h7F00, 16'h0010, 16'h8000, 16'hFFFF},
                                       '{16'h7FFF, 16'h0210, 16'h8200, 16'h01FF});
        run_vec("sub", 3'd2, 16'h0100, '{16'h8000, 16'h0000, 16'h7FFF, 16'h0100},
                                       '{16'h8000, 16'hFF00, 16'h7EFF, 16'h0000});
        run_vec("mul15", 3'd3, 16'h0180, '{16'h0200, 16'h0100, 16'hFE00, 16'h0000},
                                         '{16'h0300, 16'h0180, 16'hFD00, 16'h0000});
        run_vec("mulrnd", 3'd3, 16'h0080, '{16'h0001, 16'h0003, 16'hFFFF, 16'hFFFD},
                                          '{16'h0001, 16'h0002, 16'h0000, 16'hFFFF});
        run_vec("mulsat", 3'd3, 16'h0400, '{16'h4000, 16'hC000, 16'h0100, 16'h1FFF},
                                          '{16'h7FFF, 16'h8000, 16'h0400, 16'h7FFC});
        run_vec("relu", 3'd4, 16'h1234, '{16'hFF00, 16'h0005, 16'h8000, 16'h7FFF},
                                        '{16'h0000, 16'h0005, 16'h0000, 16'h7FFF});
        run_vec("abs", 3'd7, 16'h1234, '{16'h8000, 16'hFFFF, 16'h0003, 16'h8001},
                                       '{16'h7FFF, 16'h0001, 16'h0003, 16'h7FFF});
        run_vec("max", 3'd5, 16'h0005, '{16'hFFFF, 16'h0006, 16'h8000, 16'h7FFF},
                                       '{16'h0005, 16'h0006, 16'h0005, 16'h7FFF});
        run_vec("min", 3'd6, 16'h0005, '{16'hFFFF, 16'h0006, 16'h8000, 16'h0005},
                                       '{16'hFFFF, 16'h0005, 16'h8000, 16'h0005});
        run_vec("oplatch", 3'd1, 16'h0001, '{16'h000A, 16'h0014, 16'h001E, 16'h0028},
                                           '{16'h000B, 16'h0015, 16'h001F, 16'h0029});
        run_vec("nextpass", 3'd0, 16'h0001, '{16'h000A, 16'h0014, 16'h001E, 16'h0028},
                                            '{16'h000A, 16'h0014, 16'h001E, 16'h0028});

        // Backpressure: two ADD s=1 vectors streamed while out_ready drops for 5 cycles.
        for (int i = 0; i < 8; i++) bp_exp[i] = 16'h0101 + 16'(i);
        sent = 0; recv = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 8);
            in_valid  = (sent < 8);
            in_data   = 16'h0100 + 16'(sent);
            op        = 3'd1;
            scalar    = 16'h0001;
            #1;
            if (stalled) check("bp_hold_data", out_data, held);
            if (cyc == 6) check("bp_in_ready_low", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                check($sformatf("bp_data%0d", recv), out_data, bp_exp[recv]);
                check($sformatf("bp_last%0d", recv), out_last, (recv % VS) == VS - 1);
                recv++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            if (in_valid && in_ready) sent++;
            tick();
        end
        check("bp_all_delivered", recv, 8);
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();

        // Reset mid-vector, then a fresh vector must latch its own op at element 0.
        in_valid = 1'b1; op = 3'd1; scalar = 16'h0001; in_data = 16'h0050;
        tick();
        op = 3'd0; in_data = 16'h0060;
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_out_data", out_data, 16'h0);
        check("mrst_busy", busy, 1'b0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_vec("postrst", 3'd6, 16'h0005, '{16'hFFFF, 16'h0006, 16'h0002, 16'h0009},
                                           '{16'hFFFF, 16'h0005, 16'h0002, 16'h0005});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
